// File: rtl/i2c_req_arbiter_pkg.sv
// i2c_pkg: shared widths and state encoding for the I2C request arbiter.
package i2c_pkg;

   localparam int DEV_ADDR_W         = 7;
   localparam int INNER_ADDR_W       = 8;
   localparam int DATA_W             = 8;
   localparam int DEF_TIMEOUT_CYCLES = 4096;

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_RESP
   } state_e;

endpackage

// File: rtl/i2c_req_arbiter_if.sv
// i2c_req_arbiter_if: command/response bus between the arbiter and
// the single shared I2C byte master.
interface i2c_req_arbiter_if;
   import i2c_pkg::*;

   logic                    m_start;
   logic                    m_rw;
   logic [DEV_ADDR_W-1:0]   m_dev_addr;
   logic [INNER_ADDR_W-1:0] m_inner_addr;
   logic [DATA_W-1:0]       m_wdata;
   logic [DATA_W-1:0]       m_rdata;
   logic                    m_done;

   modport master (
      output m_start, m_rw, m_dev_addr, m_inner_addr, m_wdata,
      input  m_rdata, m_done
   );

   modport slave (
      input  m_start, m_rw, m_dev_addr, m_inner_addr, m_wdata,
      output m_rdata, m_done
   );

endinterface

// File: rtl/i2c_req_arbiter_rr.sv
// rr_arbiter: combinational round-robin pick, searching upward from
// ptr+1 with wrap; returns one-hot grant, its index and a hit flag.
module rr_arbiter #(
   parameter int N = 4
) (
   input  logic [N-1:0] req,
   input  logic [2:0]   ptr,
   output logic [N-1:0] gnt,
   output logic [2:0]   idx,
   output logic         any
);

   always_comb begin
      gnt = '0;
      idx = '0;
      any = 1'b0;
      for (int k = 1; k <= N; k++) begin
         for (int i = 0; i < N; i++) begin
            if (!any && req[i] && ((int'(ptr) + k) % N == i)) begin
               gnt[i] = 1'b1;
               idx    = 3'(i);
               any    = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/i2c_req_arbiter.sv
// i2c_req_arbiter: shares one I2C byte master among N_REQ requesters
// with round-robin grant and a per-transaction watchdog.
module i2c_req_arbiter
   import i2c_pkg::*;
#(
   parameter int N_REQ          = 4,
   parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
   parameter int CNT_W          = 12
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [N_REQ-1:0]              req,
   input  logic [N_REQ-1:0]              req_rw,
   input  logic [DEV_ADDR_W*N_REQ-1:0]   req_dev_addr,
   input  logic [INNER_ADDR_W*N_REQ-1:0] req_inner_addr,
   input  logic [DATA_W*N_REQ-1:0]       req_wdata,
   output logic [N_REQ-1:0]              resp_valid,
   output logic [DATA_W-1:0]             resp_rdata,
   output logic                          resp_err,
   output logic                          busy,
   output logic [2:0]                    grant_id,
   i2c_req_arbiter_if.master             m
);

   state_e                  state;
   state_e                  stateNext;
   logic [2:0]              ptr;
   logic [N_REQ-1:0]        gntOh;
   logic [2:0]              gntIdx;
   logic                    gntAny;
   logic                    selRw;
   logic [DEV_ADDR_W-1:0]   selDev;
   logic [INNER_ADDR_W-1:0] selInner;
   logic [DATA_W-1:0]       selWdata;
   logic                    mRw;
   logic [DEV_ADDR_W-1:0]   mDev;
   logic [INNER_ADDR_W-1:0] mInner;
   logic [DATA_W-1:0]       mWdata;
   logic [CNT_W-1:0]        wdCnt;
   logic                    doneHit;
   logic                    toHit;

   rr_arbiter #(.N(N_REQ)) uArb (
      .req (req),
      .ptr (ptr),
      .gnt (gntOh),
      .idx (gntIdx),
      .any (gntAny)
   );

   always_comb begin
      selRw    = 1'b0;
      selDev   = '0;
      selInner = '0;
      selWdata = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (gntOh[i]) begin
            selRw    = req_rw[i];
            selDev   = req_dev_addr[DEV_ADDR_W*i +: DEV_ADDR_W];
            selInner = req_inner_addr[INNER_ADDR_W*i +: INNER_ADDR_W];
            selWdata = req_wdata[DATA_W*i +: DATA_W];
         end
      end
   end

   // m_done only counts while waiting; done beats a same-cycle timeout
   assign doneHit = (state == S_WAIT) && m.m_done;
   assign toHit   = (state == S_WAIT) && !m.m_done &&
                    (wdCnt == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         S_IDLE:  if (gntAny) stateNext = S_ISSUE;
         S_ISSUE: stateNext = S_WAIT;
         S_WAIT:  if (doneHit || toHit) stateNext = S_RESP;
         S_RESP:  stateNext = S_IDLE;
         default: stateNext = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ptr        <= 3'(N_REQ - 1);
         grant_id   <= '0;
         mRw        <= 1'b0;
         mDev       <= '0;
         mInner     <= '0;
         mWdata     <= '0;
         wdCnt      <= '0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else begin
         unique case (state)
            S_IDLE: begin
               if (gntAny) begin
                  grant_id <= gntIdx;
                  mRw      <= selRw;
                  mDev     <= selDev;
                  mInner   <= selInner;
                  mWdata   <= selWdata;
               end
            end
            S_ISSUE: wdCnt <= '0;
            S_WAIT: begin
               wdCnt <= wdCnt + 1'b1;
               if (doneHit) begin
                  resp_rdata <= mRw ? m.m_rdata : '0;
                  resp_err   <= 1'b0;
               end else if (toHit) begin
                  resp_rdata <= '0;
                  resp_err   <= 1'b1;
               end
            end
            S_RESP:  ptr <= grant_id;
            default: ;
         endcase
      end
   end

   always_comb begin
      resp_valid = '0;
      if (state == S_RESP) begin
         for (int i = 0; i < N_REQ; i++) begin
            resp_valid[i] = (grant_id == 3'(i));
         end
      end
   end

   assign busy           = (state != S_IDLE);
   assign m.m_start      = (state == S_ISSUE);
   assign m.m_rw         = mRw;
   assign m.m_dev_addr   = mDev;
   assign m.m_inner_addr = mInner;
   assign m.m_wdata      = mWdata;

endmodule
